bcd_down_counter: RTL and testbench
===================================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 Parameter RELOAD, default 0; 1 = on reaching 0000, restore last loaded value and keep running.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Port load  input  1  load request for load_val, one-cycle pulse or level.
REQ-005 Port load_val  input  16  four packed BCD digits {d3,d2,d1,d0}.
REQ-006 Port start  input  1  begin countdown from the current q.
REQ-007 Port pause  input  1  level; freezes the count while high in RUN.
REQ-008 Port tick  input  1  decrement enable, sampled each clk.
REQ-009 Port q  output  16  current count, packed BCD {cnt3,cnt2,cnt1,cnt0}.
REQ-010 Port brw  output  [3:1]  combinational borrow enables; brw[k]=1 when digit k decrements this cycle.
REQ-011 Port busy  output  1  high in RUN or PAUSED.
REQ-012 Port done  output  1  registered one-cycle pulse at countdown completion.
REQ-013 Port load_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSED, encoded in two bits; no other state is reachable.
REQ-015 dec SHALL equal (state==RUN) && tick && !pause && !load.
REQ-016 On dec, digit 0 SHALL decrement, wrapping from 0 to 9.
REQ-017 Digit k (k=1..3) SHALL decrement, wrapping from 0 to 9, only when dec is high and all lower digits are 0; brw[k] SHALL equal that condition.
REQ-018 Each digit SHALL hold a value in 0..9 at all times.
REQ-019 Priority SHALL be load > start > pause > tick.
REQ-020 load with every digit of load_val <=9 SHALL set q and the reload register to load_val next edge, and force state to IDLE from any state.
REQ-021 load with any digit >9 SHALL leave q, the reload register and state unchanged and pulse load_err next edge.
REQ-022 IDLE + start with q!=0000: go to RUN; tick in the same cycle is ignored.
REQ-023 IDLE + start with q==0000: stay IDLE and pulse done next edge.
REQ-024 RUN + pause: go to PAUSED; PAUSED + !pause: return to RUN; start is ignored in RUN/PAUSED.
REQ-025 dec with q==0001: q becomes 0000 and done pulses on the same edge.
REQ-026 After that transition, with RELOAD=0 state SHALL go to IDLE.
REQ-027 After that transition, with RELOAD=1 and reload register !=0000, q SHALL take the reload value one edge later, state stays RUN, and ticks in that cycle are ignored.
REQ-028 After that transition, with RELOAD=1 and reload register ==0000, state SHALL go to IDLE.
REQ-029 dec with q==0000 in RUN cannot occur; if forced, q SHALL hold and state SHALL go to IDLE.
REQ-030 brw SHALL be 000 whenever dec is low.

Reset
REQ-031 reset_n low SHALL immediately force q=0000, reload register=0000, state=IDLE, done=0, load_err=0, independent of clk.
REQ-032 Deassertion mid-operation SHALL resume from IDLE; no countdown resumes.
REQ-033 reset_n SHALL override load/start in the same cycle.

Verification
REQ-034 load 0x0012, start, 12 ticks -> q steps 0011..0000; done pulses on the 12th-tick edge; busy falls; q then holds 0000.
REQ-035 load 0x1000, start, 1 tick -> q=0999; brw=111 during that tick cycle.
REQ-036 load 0x0A05 -> load_err pulses once; q and state unchanged; subsequent start/tick behave as before.
REQ-037 RELOAD=1, load 0x0003, start, 7 ticks -> q sequence 0002,0001,0000,0003 (reload cycle, tick ignored),0002,0001,0000; done pulses twice.
REQ-038 In RUN at q=0500: pause high for 5 ticks -> q holds 0500, busy=1; pause low then 1 tick -> q=0499.
REQ-039 reset_n low mid-RUN at q=0042 between clk edges -> q=0000 and busy=0 immediately; start after release -> done pulse, stays IDLE.

Source files
------------

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control/status bundle for the 4-digit BCD down counter
//   load, load_val[15:0], start, pause, tick : requests into the counter
//   q[15:0], brw[3:1], busy, done, load_err   : count and status out of the counter
interface bcd_down_counter_if;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        tick;
    logic [15:0] q;
    logic [3:1]  brw;
    logic        busy;
    logic        done;
    logic        load_err;
    modport master (
        output load, load_val, start, pause, tick,
        input  q, brw, busy, done, load_err
    );
    modport slave (
        input  load, load_val, start, pause, tick,
        output q, brw, busy, done, load_err
    );
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: 4-digit BCD down counter with load, start/pause control and optional auto-reload
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of bcd_down_counter_if (load/start/pause/tick in, q/brw/busy/done/load_err out)
module bcd_down_counter #(
    parameter bit RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    bcd_down_counter_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] PAUSED = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [15:0] q_q, q_d;
    logic [15:0] rld_q, rld_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;
    logic        dec, lv_ok;
    logic [3:1]  brw;

    function automatic logic [3:0] dn(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    always_comb begin
        lv_ok = (bus.load_val[3:0] <= 4'd9) && (bus.load_val[7:4] <= 4'd9) &&
                (bus.load_val[11:8] <= 4'd9) && (bus.load_val[15:12] <= 4'd9);
        dec = (state_q == RUN) && bus.tick && !bus.pause && !bus.load;
        brw[1] = dec && (q_q[3:0] == 4'd0);
        brw[2] = brw[1] && (q_q[7:4] == 4'd0);
        brw[3] = brw[2] && (q_q[11:8] == 4'd0);
        state_d = state_q;
        q_d = q_q;
        rld_d = rld_q;
        done_d = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (lv_ok) begin
                q_d = bus.load_val;
                rld_d = bus.load_val;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                // starting an already-empty counter completes immediately
                done_d = (q_q == 16'h0000);
                state_d = (q_q == 16'h0000) ? IDLE : RUN;
            end
        end else if (state_q == RUN) begin
            if (bus.pause) begin
                state_d = PAUSED;
            end else if (q_q == 16'h0000) begin
                // only reached in the reload cycle after expiry; any tick here is dropped
                if (RELOAD && rld_q != 16'h0000) q_d = rld_q;
                else state_d = IDLE;
            end else if (bus.tick) begin
                q_d = {brw[3] ? dn(q_q[15:12]) : q_q[15:12],
                       brw[2] ? dn(q_q[11:8])  : q_q[11:8],
                       brw[1] ? dn(q_q[7:4])   : q_q[7:4],
                       dn(q_q[3:0])};
                if (q_q == 16'h0001) begin
                    done_d = 1'b1;
                    state_d = (RELOAD && rld_q != 16'h0000) ? RUN : IDLE;
                end
            end
        end else if (state_q == PAUSED) begin
            state_d = bus.pause ? PAUSED : RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q <= 16'h0000;
            rld_q <= 16'h0000;
            done_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q <= q_d;
            rld_q <= rld_d;
            done_q <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q = q_q;
    assign bus.brw = brw;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed self-checking bench for bcd_down_counter (RELOAD=0 and RELOAD=1 copies)
module tb_bcd_down_counter;
    logic clk = 1'b0;
    logic reset_n;
    int total = 0;
    int bad = 0;

    bcd_down_counter_if if0 ();
    bcd_down_counter_if if1 ();

    assign if1.load = if0.load;
    assign if1.load_val = if0.load_val;
    assign if1.start = if0.start;
    assign if1.pause = if0.pause;
    assign if1.tick = if0.tick;

    bcd_down_counter #(.RELOAD(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    bcd_down_counter #(.RELOAD(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        if0.load = 1'b1;
        if0.load_val = v;
        cyc();
        if0.load = 1'b0;
    endtask

    task automatic do_start;
        if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
    endtask

    logic [15:0] exp12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    logic [15:0] exp7 [7] = '{16'h0002, 16'h0001, 16'h0000, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    logic        dn7 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        if0.load = 1'b0;
        if0.load_val = 16'h0000;
        if0.start = 1'b0;
        if0.pause = 1'b0;
        if0.tick = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_q", 32'(if0.q), 32'h0000);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_lerr", 32'(if0.load_err), 0);
        cyc();
        cyc();
        reset_n = 1'b1;

        do_load(16'h0012);
        chk("ld12_q", 32'(if0.q), 32'h0012);
        chk("ld12_busy", 32'(if0.busy), 0);
        do_start();
        chk("st12_busy", 32'(if0.busy), 1);
        if0.tick = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk($sformatf("cnt12_q%0d", i), 32'(if0.q), 32'(exp12[i]));
            chk($sformatf("cnt12_done%0d", i), 32'(if0.done), (i == 11) ? 1 : 0);
            if (i == 1) chk("brw_0010", 32'(if0.brw), 32'b001);
        end
        chk("end12_busy", 32'(if0.busy), 0);
        chk("end12_brw", 32'(if0.brw), 0);
        cyc();
        chk("hold12_q", 32'(if0.q), 32'h0000);
        chk("hold12_done", 32'(if0.done), 0);
        if0.tick = 1'b0;

        do_load(16'h1000);
        do_start();
        if0.tick = 1'b1;
        #1;
        chk("brw_1000", 32'(if0.brw), 32'b111);
        cyc();
        if0.tick = 1'b0;
        chk("q_0999", 32'(if0.q), 32'h0999);

        do_load(16'h0005);
        if0.start = 1'b1;
        if0.tick = 1'b1;
        cyc();
        if0.start = 1'b0;
        chk("st_tick_ign_q", 32'(if0.q), 32'h0005);
        chk("st_tick_busy", 32'(if0.busy), 1);
        cyc();
        if0.tick = 1'b0;
        chk("q_0004", 32'(if0.q), 32'h0004);
        do_load(16'h0000);
        chk("ld_run_idle", 32'(if0.busy), 0);
        do_start();
        chk("st_zero_done", 32'(if0.done), 1);
        chk("st_zero_busy", 32'(if0.busy), 0);
        cyc();
        chk("st_zero_done2", 32'(if0.done), 0);

        do_load(16'h0007);
        do_start();
        if0.tick = 1'b1;
        do_load(16'h0A05);
        chk("lerr_pulse", 32'(if0.load_err), 1);
        chk("lerr_q", 32'(if0.q), 32'h0007);
        chk("lerr_busy", 32'(if0.busy), 1);
        cyc();
        if0.tick = 1'b0;
        chk("lerr_clr", 32'(if0.load_err), 0);
        chk("lerr_after_q", 32'(if0.q), 32'h0006);

        do_load(16'h0003);
        do_start();
        if0.tick = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk($sformatf("rld_q%0d", i), 32'(if1.q), 32'(exp7[i]));
            chk($sformatf("rld_done%0d", i), 32'(if1.done), 32'(dn7[i]));
        end
        if0.tick = 1'b0;
        chk("rld_busy", 32'(if1.busy), 1);
        chk("norld_busy", 32'(if0.busy), 0);
        chk("norld_q", 32'(if0.q), 32'h0000);

        do_load(16'h0501);
        do_start();
        if0.tick = 1'b1;
        cyc();
        chk("q_0500", 32'(if0.q), 32'h0500);
        if0.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("pause_q%0d", i), 32'(if0.q), 32'h0500);
            chk($sformatf("pause_busy%0d", i), 32'(if0.busy), 1);
        end
        if0.pause = 1'b0;
        if0.tick = 1'b0;
        cyc();
        chk("resume_q", 32'(if0.q), 32'h0500);
        if0.tick = 1'b1;
        cyc();
        if0.tick = 1'b0;
        chk("q_0499", 32'(if0.q), 32'h0499);

        do_load(16'h0043);
        do_start();
        if0.tick = 1'b1;
        cyc();
        if0.tick = 1'b0;
        chk("q_0042", 32'(if0.q), 32'h0042);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q", 32'(if0.q), 32'h0000);
        chk("arst_busy", 32'(if0.busy), 0);
        if0.load = 1'b1;
        if0.load_val = 16'h1234;
        cyc();
        if0.load = 1'b0;
        chk("rst_over_load", 32'(if0.q), 32'h0000);
        reset_n = 1'b1;
        do_start();
        chk("post_rst_done", 32'(if0.done), 1);
        chk("post_rst_busy", 32'(if0.busy), 0);
        cyc();
        chk("post_rst_done2", 32'(if0.done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
